// File: rtl/mux_arb_n_pkg.sv
// Shared constants for the arbitrated selector: mode encodings.
package mux_arb_pkg;

    localparam logic [1:0] MODE_RR     = 2'd0;
    localparam logic [1:0] MODE_FIXED  = 2'd1;
    localparam logic [1:0] MODE_DIRECT = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

endpackage

// File: rtl/mux_arb_n_if.sv
// Handshake/bus bundle for mux_arb_n: N input channels plus one registered output channel.
interface mux_arb_n_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 8
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);

    logic [1:0]              mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;

    // Arbiter side
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

    // Source/sink side
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/mux_arb_n_rr_priority_pick.sv
// Combinational rotating priority picker: first set request at or after 'start',
// wrapping modulo NUM_IN. With start=0 it is a plain lowest-index-wins picker.
module rr_priority_pick #(
    parameter int unsigned NUM_IN = 8
) (
    input  logic [NUM_IN-1:0]         req,
    input  logic [$clog2(NUM_IN)-1:0] start,
    output logic [NUM_IN-1:0]         grant,
    output logic [$clog2(NUM_IN)-1:0] idx
);
    localparam int unsigned IDX_W = $clog2(NUM_IN);

    logic [NUM_IN-1:0] rot;
    logic              found;
    int unsigned       ff;
    int unsigned       j;
    int unsigned       abs_idx;

    // Rotate so 'start' sits at bit 0, find first set, then rotate the index back.
    // Modulo is done by conditional subtract so non-power-of-2 sizes wrap correctly.
    always_comb begin
        rot     = '0;
        found   = 1'b0;
        ff      = 0;
        j       = 0;
        abs_idx = 0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            j = i + int'(start);
            if (j >= NUM_IN) j = j - NUM_IN;
            rot[i] = req[j];
        end
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                ff    = i;
            end
        end
        abs_idx = ff + int'(start);
        if (abs_idx >= NUM_IN) abs_idx = abs_idx - NUM_IN;
        idx   = found ? IDX_W'(abs_idx) : '0;
        grant = '0;
        if (found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-input arbitrated selector with single-entry registered output and valid/ready
// handshakes on both sides. Round-robin, fixed-priority or direct-select arbitration.
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    mux_arb_n_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);

    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_src_q, out_src_d;

    logic [SEL_W-1:0]  start;
    logic [NUM_IN-1:0] pick_grant;
    logic [SEL_W-1:0]  pick_idx;
    logic [NUM_IN-1:0] dir_grant;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              load;
    logic              xfer;
    logic [WIDTH-1:0]  sel_data;

    // Search origin: rr pointer in round-robin, channel 0 for fixed priority.
    always_comb begin
        start = (bus.mode == MODE_RR) ? ptr_q : '0;
    end

    rr_priority_pick #(.NUM_IN(NUM_IN)) u_pick (
        .req   (bus.in_valid),
        .start (start),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Direct select: only the addressed channel can win; out-of-range sel matches nothing.
    always_comb begin
        dir_grant = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            dir_grant[i] = bus.in_valid[i] && (bus.sel == SEL_W'(i));
        end
    end

    // Mode decode into a single one-hot grant and its index.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        case (bus.mode)
            MODE_RR, MODE_FIXED: begin
                grant     = pick_grant;
                grant_idx = pick_idx;
            end
            MODE_DIRECT: begin
                grant     = dir_grant;
                grant_idx = bus.sel;
            end
            default: begin
                grant     = '0;
                grant_idx = '0;
            end
        endcase
    end

    // Handshake: the output register can take a word when empty or being drained.
    always_comb begin
        load         = !out_valid_q || bus.out_ready;
        bus.in_ready = (reset_n && load) ? grant : '0;
        xfer         = |bus.in_ready;
    end

    // One-hot data mux over the granted channel.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            sel_data = sel_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    // Next state for output register and rr pointer; everything holds while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = sel_data;
                out_src_d  = grant_idx;
            end
        end
        if (xfer && (bus.mode == MODE_RR)) begin
            ptr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    // Drive registered outputs onto the bus.
    always_comb begin
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_src   = out_src_q;
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed scoreboard bench for mux_arb_n: an 8-channel and a 5-channel instance.
module tb_mux_arb_n;
    localparam int unsigned W = 32;

    typedef struct {
        int          src;
        logic [31:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    mux_arb_n_if #(.WIDTH(W), .NUM_IN(8)) b8 ();
    mux_arb_n_if #(.WIDTH(W), .NUM_IN(5)) b5 ();

    mux_arb_n #(.WIDTH(W), .NUM_IN(8)) u8 (.clock(clock), .reset_n(reset_n), .bus(b8));
    mux_arb_n #(.WIDTH(W), .NUM_IN(5)) u5 (.clock(clock), .reset_n(reset_n), .bus(b5));

    int checks = 0;
    int errors = 0;

    logic [31:0] d8 [8];
    logic [31:0] d5 [5];
    exp_t        q8 [$];
    exp_t        q5 [$];
    exp_t        h8, h5;
    int          m_ptr8, m_ptr5;
    logic        m_ov8, m_ov5;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] v, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    // One cycle on the 8-channel instance; entered and left at posedge+1.
    task automatic drive8(input logic [1:0] md, input int sl, input logic [7:0] v, input logic ordy);
        int   g;
        logic load;
        exp_t e;
        b8.mode      = md;
        b8.sel       = 3'(sl);
        b8.in_valid  = v;
        b8.out_ready = ordy;
        for (int i = 0; i < 8; i++) b8.in_data[i*W +: W] = d8[i];
        load = !m_ov8 || ordy;
        case (md)
            2'd0:    g = pick(v, m_ptr8, 8);
            2'd1:    g = pick(v, 0, 8);
            2'd2:    g = (sl < 8 && v[sl]) ? sl : -1;
            default: g = -1;
        endcase
        #1;
        chk("in_ready8", 64'(b8.in_ready), (load && g >= 0) ? (64'd1 << g) : 64'd0);
        if (load) begin
            if (g >= 0) begin
                q8.push_back('{g, d8[g]});
                if (md == 2'd0) m_ptr8 = (g + 1) % 8;
            end
            m_ov8 = (g >= 0);
        end
        @(posedge clock);
        #1;
        chk("out_valid8", 64'(b8.out_valid), 64'(m_ov8));
        if (load && g >= 0) begin
            e  = q8.pop_front();
            h8 = e;
            chk("out_src8", 64'(b8.out_src), 64'(e.src));
            chk("out_data8", 64'(b8.out_data), 64'(e.data));
        end else if (m_ov8) begin
            chk("hold_src8", 64'(b8.out_src), 64'(h8.src));
            chk("hold_data8", 64'(b8.out_data), 64'(h8.data));
        end
    endtask

    // One cycle on the 5-channel instance.
    task automatic drive5(input logic [1:0] md, input int sl, input logic [4:0] v, input logic ordy);
        int   g;
        logic load;
        exp_t e;
        b5.mode      = md;
        b5.sel       = 3'(sl);
        b5.in_valid  = v;
        b5.out_ready = ordy;
        for (int i = 0; i < 5; i++) b5.in_data[i*W +: W] = d5[i];
        load = !m_ov5 || ordy;
        case (md)
            2'd0:    g = pick({3'b0, v}, m_ptr5, 5);
            2'd1:    g = pick({3'b0, v}, 0, 5);
            2'd2:    g = (sl < 5 && v[sl]) ? sl : -1;
            default: g = -1;
        endcase
        #1;
        chk("in_ready5", 64'(b5.in_ready), (load && g >= 0) ? (64'd1 << g) : 64'd0);
        if (load) begin
            if (g >= 0) begin
                q5.push_back('{g, d5[g]});
                if (md == 2'd0) m_ptr5 = (g + 1) % 5;
            end
            m_ov5 = (g >= 0);
        end
        @(posedge clock);
        #1;
        chk("out_valid5", 64'(b5.out_valid), 64'(m_ov5));
        if (load && g >= 0) begin
            e  = q5.pop_front();
            h5 = e;
            chk("out_src5", 64'(b5.out_src), 64'(e.src));
            chk("out_data5", 64'(b5.out_data), 64'(e.data));
        end else if (m_ov5) begin
            chk("hold_src5", 64'(b5.out_src), 64'(h5.src));
            chk("hold_data5", 64'(b5.out_data), 64'(h5.data));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        b8.mode = 2'd0; b8.sel = '0; b8.in_valid = '0; b8.in_data = '0; b8.out_ready = 1'b0;
        b5.mode = 2'd0; b5.sel = '0; b5.in_valid = '0; b5.in_data = '0; b5.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) d8[i] = 32'hC0DE_0000 | 32'(i);
        for (int i = 0; i < 5; i++) d5[i] = 32'h5A5A_0000 | 32'(i);
        m_ptr8 = 0; m_ptr5 = 0; m_ov8 = 1'b0; m_ov5 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid8", 64'(b8.out_valid), 64'd0);
        chk("rst_out_data8", 64'(b8.out_data), 64'd0);
        chk("rst_out_src8", 64'(b8.out_src), 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Round-robin fairness: all valid, output always drained.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 8; i++) d8[i] = {8'hA5, 8'(k), 8'h00, 8'(i)};
            drive8(2'd0, 0, 8'hFF, 1'b1);
            chk("rr_seq", 64'(b8.out_src), 64'(k % 8));
        end

        // Backpressure: ch3 loads DEADBEEF, then output stalls for 3 cycles.
        d8[3] = 32'hDEAD_BEEF;
        drive8(2'd0, 0, 8'b0000_1000, 1'b1);
        chk("bp_load_data", 64'(b8.out_data), 64'h0000_0000_DEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            drive8(2'd0, 0, 8'hFF, 1'b0);
            chk("bp_stall_data", 64'(b8.out_data), 64'h0000_0000_DEAD_BEEF);
            chk("bp_ptr", 64'(u8.ptr_q), 64'd4);
        end
        drive8(2'd0, 0, 8'hFF, 1'b1);
        chk("bp_next_grant", 64'(b8.out_src), 64'd4);

        // Fixed priority: sources drop valid once served.
        drive8(2'd1, 0, 8'b1010_0100, 1'b1);
        chk("fp_first", 64'(b8.out_src), 64'd2);
        drive8(2'd1, 0, 8'b1010_0000, 1'b1);
        chk("fp_second", 64'(b8.out_src), 64'd5);
        drive8(2'd1, 0, 8'b1000_0000, 1'b1);
        chk("fp_third", 64'(b8.out_src), 64'd7);
        chk("fp_ptr_held", 64'(u8.ptr_q), 64'd5);

        // Direct select.
        d8[6] = 32'h0000_1234;
        drive8(2'd2, 6, 8'b0100_0000, 1'b1);
        chk("dir_src", 64'(b8.out_src), 64'd6);
        drive8(2'd2, 6, 8'b1011_1111, 1'b1);
        chk("dir_drop", 64'(b8.out_valid), 64'd0);
        drive8(2'd2, 1, 8'hFF, 1'b1);
        chk("dir_ptr_held", 64'(u8.ptr_q), 64'd5);

        // Reserved mode never grants.
        drive8(2'd3, 0, 8'hFF, 1'b1);

        // Odd size wrap: move pointer to 4, then wrap to ch0 and ch1.
        drive5(2'd0, 0, 5'b01000, 1'b1);
        chk("wrap_ptr4", 64'(u5.ptr_q), 64'd4);
        drive5(2'd0, 0, 5'b00011, 1'b1);
        chk("wrap_ch0", 64'(b5.out_src), 64'd0);
        drive5(2'd0, 0, 5'b00011, 1'b1);
        chk("wrap_ch1", 64'(b5.out_src), 64'd1);
        drive5(2'd2, 5, 5'b11111, 1'b1);
        drive5(2'd2, 4, 5'b11111, 1'b0);
        drive5(2'd2, 4, 5'b11111, 1'b0);

        // Asynchronous reset mid-transfer, away from any clock edge.
        drive8(2'd0, 0, 8'hFF, 1'b1);
        chk("pre_rst_valid", 64'(b8.out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(b8.out_valid), 64'd0);
        chk("arst_out_data", 64'(b8.out_data), 64'd0);
        chk("arst_out_src", 64'(b8.out_src), 64'd0);
        chk("arst_in_ready", 64'(b8.in_ready), 64'd0);
        chk("arst_ptr", 64'(u8.ptr_q), 64'd0);
        chk("arst_out_valid5", 64'(b5.out_valid), 64'd0);
        chk("arst_out_data5", 64'(b5.out_data), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
